nrisc_ula_muldiv_seq: RTL and testbench

//  Multi-cycle unsigned multiply/divide sequencer that time-multiplexes the combinational NRISC ALU (ULA).

---
 rtl/nrisc_ula_muldiv_seq.sv | 135 +++++++++++++
 tb/tb_nrisc_ula_muldiv_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/nrisc_ula_muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer that borrows the combinational ULA
// one bit per clock: shift-add multiply via ULA ADD, restoring divide via ULA SUB.
module nrisc_ula_muldiv_seq #(
  parameter int TAM = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op,
  input  logic [TAM-1:0] opa,
  input  logic [TAM-1:0] opb,
  output logic           busy,
  output logic           done,
  output logic [TAM-1:0] res_hi,
  output logic [TAM-1:0] res_lo,
  output logic           div0,
  output logic [TAM-1:0] ula_a,
  output logic [TAM-1:0] ula_b,
  output logic [3:0]     ula_ctrl,
  output logic           ula_incdec,
  input  logic [TAM-1:0] ula_out
);

  localparam int CW = (TAM > 1) ? $clog2(TAM) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic           op_r;
  logic [CW-1:0]  cnt;
  logic [TAM-1:0] phi, plo, m;
  logic [TAM-1:0] r, q, d;

  logic           last;
  logic [TAM:0]   trial;
  logic           ge;
  logic [TAM-1:0] mul_s;
  logic           mul_c;
  logic [TAM-1:0] phi_nxt, plo_nxt, r_nxt, q_nxt;

  assign last  = (cnt == CW'(TAM - 1));
  assign trial = {r, q[TAM-1]};
  assign ge    = trial[TAM] | (trial[TAM-1:0] >= d);
  // ULA_flags[0] is not a real carry, so the carry comes from the wrap-around compare
  assign mul_s   = plo[0] ? ula_out : phi;
  assign mul_c   = plo[0] & (ula_out < phi);
  assign phi_nxt = {mul_c, mul_s[TAM-1:1]};
  assign plo_nxt = {mul_s[0], plo[TAM-1:1]};
  assign r_nxt   = ge ? ula_out : trial[TAM-1:0];
  assign q_nxt   = {q[TAM-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (op && opb == '0) ? DONE : RUN;
      RUN:  if (last)  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == RUN);
    done       = (state == DONE);
    ula_a      = '0;
    ula_b      = '0;
    ula_ctrl   = 4'b0000;
    ula_incdec = 1'b0;
    if (state == RUN) begin
      if (op_r) begin
        ula_a    = trial[TAM-1:0];
        ula_b    = d;
        ula_ctrl = 4'b0001;
      end else begin
        ula_a    = phi;
        ula_b    = m;
      end
    end
  end

  // Operand capture, per-step datapath update and result latch on the final step
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r   <= 1'b0;
      cnt    <= '0;
      phi    <= '0;
      plo    <= '0;
      m      <= '0;
      r      <= '0;
      q      <= '0;
      d      <= '0;
      res_hi <= '0;
      res_lo <= '0;
      div0   <= 1'b0;
    end else if (state == IDLE && start) begin
      op_r <= op;
      if (op && opb == '0) begin
        div0   <= 1'b1;
        res_lo <= '1;
        res_hi <= opa;
      end else begin
        cnt  <= '0;
        div0 <= 1'b0;
        if (op) begin
          d <= opb;
          r <= '0;
          q <= opa;
        end else begin
          m   <= opa;
          phi <= '0;
          plo <= opb;
        end
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (op_r) begin
        r <= r_nxt;
        q <= q_nxt;
      end else begin
        phi <= phi_nxt;
        plo <= plo_nxt;
      end
      if (last) begin
        res_hi <= op_r ? r_nxt : phi_nxt;
        res_lo <= op_r ? q_nxt : plo_nxt;
      end
    end
  end

endmodule

// File: tb/tb_nrisc_ula_muldiv_seq.sv
// Scoreboard bench for the mul/div sequencer: directed operations push expected
// results and done-cycle into a queue; a monitor pops and compares on every done.
module tb_nrisc_ula_muldiv_seq;

  localparam int TAM = 16;

  typedef struct {
    logic [TAM-1:0] hi;
    logic [TAM-1:0] lo;
    logic           dz;
    int             doneCyc;
  } expect_t;

  logic           clk = 1'b0;
  logic           rst, start, op;
  logic [TAM-1:0] opa, opb;
  logic           busy, done, div0, ula_incdec;
  logic [TAM-1:0] res_hi, res_lo, ula_a, ula_b, ula_out;
  logic [3:0]     ula_ctrl;

  expect_t expQ[$];
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;

  nrisc_ula_muldiv_seq #(.TAM(TAM)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .div0(div0),
    .ula_a(ula_a), .ula_b(ula_b), .ula_ctrl(ula_ctrl), .ula_incdec(ula_incdec),
    .ula_out(ula_out)
  );

  // Behavioural stand-in for the combinational ULA (wraps mod 2^TAM)
  assign ula_out = (ula_ctrl == 4'b0001) ? ula_a - ula_b : ula_a + ula_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic waitDone();
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("doneTimeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic applyStimulus(input logic o, input logic [TAM-1:0] a, input logic [TAM-1:0] b,
                               input logic [TAM-1:0] hi, input logic [TAM-1:0] lo, input logic dz);
    expect_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    e.hi = hi;
    e.lo = lo;
    e.dz = dz;
    e.doneCyc = cyc + (dz ? 1 : TAM + 1);
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op    = ~o;
    opa   = 16'h5A5A;
    opb   = 16'h0000;
    waitDone();
  endtask

  always @(negedge clk) begin
    expect_t e;
    if (!rst) begin
      checkOutput("ulaIncdec", {31'd0, ula_incdec}, 32'd0);
      checkOutput("ulaCtrlLegal", {31'd0, ula_ctrl[3:1] == 3'b000}, 32'd1);
      if (!busy) checkOutput("ulaIdleZero", {ula_a, ula_b}, 32'd0);
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDone", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("result", {res_hi, res_lo}, {e.hi, e.lo});
          checkOutput("div0", {31'd0, div0}, {31'd0, e.dz});
          checkOutput("latency", cyc, e.doneCyc);
          checkOutput("busyInDone", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  initial begin
    expect_t e;
    rst = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetState", {busy, done, div0, ula_a, ula_b[12:0]}, 32'd0);
    checkOutput("resetRes", {res_hi, res_lo}, 32'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0);
    applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 16'h0007, 16'h0001, 16'h2492, 1'b0);
    applyStimulus(1'b1, 16'h8000, 16'h8001, 16'h8000, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 1'b0);
    applyStimulus(1'b1, 16'd100,  16'd10,   16'd0,    16'd10,   1'b0);
    applyStimulus(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1);
    @(negedge clk);
    checkOutput("div0Held", {15'd0, div0, res_lo}, {15'd0, 1'b1, 16'hFFFF});
    applyStimulus(1'b0, 16'h0002, 16'h0003, 16'h0000, 16'h0006, 1'b0);

    // A start pulse mid-run (div-by-zero operands) must be ignored
    @(negedge clk);
    start = 1'b1; op = 1'b0; opa = 16'h00FF; opb = 16'h0101;
    e.hi = 16'h0000; e.lo = 16'hFFFF; e.dz = 1'b0; e.doneCyc = cyc + TAM + 1;
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("busyInRun", {31'd0, busy}, 32'd1);
    start = 1'b1; op = 1'b1; opa = 16'h0005; opb = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    waitDone();

    // Abort a multiply part-way through with reset
    @(negedge clk);
    start = 1'b1; op = 1'b0; opa = 16'hFFFF; opb = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abortFlags", {29'd0, busy, done, div0}, 32'd0);
    checkOutput("abortRes", {res_hi, res_lo}, 32'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("queueEmpty", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
